// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch stage: fetches sequential words from a wait-stated memory
// into a small FIFO and redirects whenever the core PC leaves the sequential stream.
`timescale 1ns/1ps
module instr_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_in,
    input  logic        take,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic        stall,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [15:0]      buf_addr [DEPTH];
    logic [15:0]      buf_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;
    logic [15:0]      fetch_addr;

    logic empty;
    logic head_hit;
    logic mismatch;
    logic pop;
    logic push;
    logic issue;

    // fetch_addr stays equal to the outstanding address while BUSY, so it is
    // always the next address the empty buffer expects to see.
    assign empty       = (count == '0);
    assign head_hit    = !empty && (buf_addr[head] == pc_in);
    assign mismatch    = empty ? (fetch_addr != pc_in) : (buf_addr[head] != pc_in);
    assign instr_valid = head_hit;
    assign instr_out   = head_hit ? buf_data[head] : 16'h0000;
    assign stall       = !head_hit;
    assign pop         = head_hit && take;
    assign push        = (state == BUSY) && mem_ack && !mismatch;
    assign issue       = (state == IDLE) && !mismatch && (count < FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            state      <= IDLE;
            fetch_addr <= RESET_PC;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_PC;
        end else if (mismatch) begin
            // Redirect: flush, retarget, and let any in-flight read retire as stale.
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fetch_addr <= pc_in;
            case (state)
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: ;
            endcase
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);

            case (state)
                IDLE: begin
                    if (issue) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_addr;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        fetch_addr <= mem_addr + 16'd1;
                        mem_req    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage carries no reset; entries are only observed while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= mem_addr;
            buf_data[tail] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with a wait-state memory responder
// and queue-based expectations for issued addresses and delivered words.
`timescale 1ns/1ps
module tb_instr_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_in;
    logic        take;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    int ack_delay = 0;
    int mem_cnt   = 0;
    bit mem_seen  = 0;

    logic [15:0] issued_q  [$];
    logic [15:0] exp_issue [$];
    logic [15:0] exp_q     [$];

    instr_prefetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .take       (take),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: logs each new request, acks after ack_delay extra req cycles, data = addr ^ A5A5.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                mem_ack  = 1'b0;
                mem_cnt  = 0;
                mem_seen = 0;
            end else begin
                if (!mem_seen) begin
                    issued_q.push_back(mem_addr);
                    mem_seen = 1;
                end
                if (mem_ack) begin
                    mem_ack = 1'b0;
                end else if (mem_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ 16'hA5A5;
                end else begin
                    mem_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        pc_in     = 16'h0000;
        take      = 1'b0;
        ack_delay = 0;
        repeat (3) @(posedge clk);
        #1;
        issued_q.delete();
        exp_q.delete();
        rst = 1'b1;
    endtask

    // Core model: present each sequential PC, wait for it to become valid, take it.
    task automatic consume(input logic [15:0] start, input int n);
        logic [15:0] a;
        logic [15:0] expd;
        int          w;
        for (int i = 0; i < n; i++) begin
            a     = start + 16'(i);
            pc_in = a;
            take  = 1'b1;
            exp_q.push_back(a ^ 16'hA5A5);
            #1;
            w = 0;
            while (!instr_valid && w < 30) begin
                tick();
                w++;
            end
            chk("deliver_valid", 32'(instr_valid), 1);
            expd = exp_q.pop_front();
            chk("deliver_data", 32'(instr_out), 32'(expd));
            tick();
        end
        pc_in = start + 16'(n);
        take  = 1'b0;
        #1;
    endtask

    task automatic check_issues(input string tag);
        logic [15:0] e;
        while (exp_issue.size() != 0) begin
            e = exp_issue.pop_front();
            chk({tag, "_present"}, 32'(issued_q.size() != 0), 1);
            if (issued_q.size() != 0) chk(tag, 32'(issued_q.pop_front()), 32'(e));
        end
        issued_q.delete();
    endtask

    initial begin
        int  w;
        bit  stall_seen;

        // Reset state
        rst = 1'b0; pc_in = 16'h0000; take = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req",     32'(mem_req), 0);
        chk("rst_mem_addr",    32'(mem_addr), 32'h0000);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_instr_out",   32'(instr_out), 32'h0000);
        chk("rst_stall",       32'(stall), 1);

        // Release: first request, first push, then fill to DEPTH and stop
        rst = 1'b1;
        tick();
        chk("first_req",   32'(mem_req), 1);
        chk("first_addr",  32'(mem_addr), 32'h0000);
        chk("first_valid", 32'(instr_valid), 0);
        tick();
        chk("entry0_valid", 32'(instr_valid), 1);
        chk("entry0_data",  32'(instr_out), 32'hA5A5);
        chk("entry0_stall", 32'(stall), 0);
        stall_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (stall) stall_seen = 1;
        end
        chk("stall_held_low", 32'(stall_seen), 0);
        chk("full_no_req",    32'(mem_req), 0);
        chk("full_req_count", 32'(issued_q.size()), 4);
        for (int i = 0; i < 4; i++) exp_issue.push_back(16'(i));
        check_issues("fill_addr");

        // Drain 0..3 back to back, refetch resumes at 4
        consume(16'h0000, 4);
        consume(16'h0004, 1);
        exp_issue.push_back(16'h0004);
        check_issues("refetch_addr");

        // Jump while request for address 5 is waiting on a 3-cycle ack
        do_reset();
        repeat (10) tick();
        consume(16'h0000, 2);
        tick();
        issued_q.delete();
        ack_delay = 3;
        tick();
        chk("pend5_req",  32'(mem_req), 1);
        chk("pend5_addr", 32'(mem_addr), 32'h0005);
        pc_in = 16'h0040;
        #1;
        chk("jump_valid", 32'(instr_valid), 0);
        chk("jump_stall", 32'(stall), 1);
        tick();
        chk("drain_req_held", 32'(mem_req), 1);
        chk("drain_addr_held", 32'(mem_addr), 32'h0005);
        chk("drain_valid",    32'(instr_valid), 0);
        w = 0;
        while (mem_req && w < 10) begin
            tick();
            w++;
        end
        chk("drain_done",       32'(mem_req), 0);
        chk("drain_discard_vld", 32'(instr_valid), 0);
        ack_delay = 0;
        tick();
        chk("redirect_req",  32'(mem_req), 1);
        chk("redirect_addr", 32'(mem_addr), 32'h0040);
        consume(16'h0040, 1);
        exp_issue.push_back(16'h0005);
        exp_issue.push_back(16'h0040);
        check_issues("jump_addr");

        // PC change in the same cycle as mem_ack
        ack_delay = 2;
        w = 0;
        while (!mem_ack && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("ack_seen", 32'(mem_ack), 1);
        pc_in = 16'h0100;
        tick();
        chk("ackjump_req",   32'(mem_req), 0);
        chk("ackjump_valid", 32'(instr_valid), 0);
        ack_delay = 0;
        tick();
        chk("ackjump_next_req",  32'(mem_req), 1);
        chk("ackjump_next_addr", 32'(mem_addr), 32'h0100);
        consume(16'h0100, 1);
        exp_issue.push_back(16'h0041);
        exp_issue.push_back(16'h0100);
        check_issues("ackjump_addr");

        // Sequential run across the 16-bit wrap
        repeat (10) tick();
        chk("prewrap_full_no_req", 32'(mem_req), 0);
        issued_q.delete();
        consume(16'hFFFE, 3);
        exp_issue.push_back(16'hFFFE);
        exp_issue.push_back(16'hFFFF);
        exp_issue.push_back(16'h0000);
        check_issues("wrap_addr");

        // Asynchronous reset while a request is outstanding
        ack_delay = 5;
        w = 0;
        while (!(mem_req && instr_valid) && w < 40) begin
            tick();
            w++;
        end
        chk("busy_before_rst", 32'(mem_req && instr_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_req",   32'(mem_req), 0);
        chk("async_rst_valid", 32'(instr_valid), 0);
        chk("async_rst_out",   32'(instr_out), 32'h0000);
        chk("async_rst_addr",  32'(mem_addr), 32'h0000);
        pc_in     = 16'h0000;
        ack_delay = 0;
        tick();
        chk("rst_hold_req", 32'(mem_req), 0);
        issued_q.delete();
        rst = 1'b1;
        tick();
        chk("post_rst_req",  32'(mem_req), 1);
        chk("post_rst_addr", 32'(mem_addr), 32'h0000);
        tick();
        chk("post_rst_valid", 32'(instr_valid), 1);
        chk("post_rst_data",  32'(instr_out), 32'hA5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
